// File: rtl/inv_shift_rows_stage_if.sv
// Valid/ready stream carrying one 128-bit AES state per handshake.
// The master drives valid/data and the slave answers with ready.
interface inv_shift_rows_stage_if;
    logic         valid;
    logic         ready;
    logic [127:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/inv_shift_rows_stage.sv
// Registered AES (Inv)ShiftRows stage with a two-entry skid buffer.
// The main register M drives the output and the skid register S catches
// the one extra state that can arrive while the output is stalled. Because
// of S, in_ready can come from a flop and throughput still reaches one
// state per cycle.
// The byte permutation is applied as a state is captured, so both M and S
// always hold already-transformed states.
module inv_shift_rows_stage #(
    parameter bit INVERSE = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    inv_shift_rows_stage_if.slave         in_if,
    inv_shift_rows_stage_if.master        out_if,
    output logic [CNT_W-1:0]              blk_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       m_q, m_d;
    logic [127:0]       s_q, s_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               out_valid;
    logic               accept;
    logic               consume;
    logic [127:0]       xformed;

    // Row r of the state is rotated by r byte positions. Byte k sits at
    // [127-8k -: 8] and s(r,c) is byte 4c+r. The inverse direction takes
    // from column c-r, the forward direction from column c+r.
    function automatic logic [127:0] shift_state(input logic [127:0] st);
        logic [127:0] res;
        int           src_c;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (INVERSE) begin
                    src_c = (c - r + 4) % 4;
                end else begin
                    src_c = (c + r) % 4;
                end
                res[127-8*(4*c+r) -: 8] = st[127-8*(4*src_c+r) -: 8];
            end
        end
        return res;
    endfunction

    assign accept  = in_if.valid & in_ready_q;
    assign consume = out_valid & out_if.ready;
    assign xformed = shift_state(in_if.data);

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid;
    assign out_if.data  = m_q;
    assign blk_cnt      = blk_cnt_q;

    // Occupancy register; reset empties the buffer and drops both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy follows accepts (fill) and consumes (drain).
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !consume) begin
                    state_d = TWO;
                end else if (consume && !accept) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Output valid comes from occupancy. in_ready is precomputed from the
    // next occupancy so that it can be registered.
    always_comb begin
        out_valid  = (state_q != EMPTY);
        in_ready_d = (state_d != TWO);
    end

    // Choose what M, S and the block counter hold next. M keeps its value
    // when it empties, so out_data never shows an undefined value.
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        blk_cnt_d = blk_cnt_q + {{(CNT_W-1){1'b0}}, consume};
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_d = xformed;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    m_d = xformed;
                end else if (accept) begin
                    s_d = xformed;
                end
            end
            TWO: begin
                if (consume) begin
                    m_d = s_q;
                end
            end
            default: begin
                m_d = m_q;
            end
        endcase
    end

    // Data, ready and counter registers. in_ready stays low during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Self-checking bench for inv_shift_rows_stage: directed vectors, backpressure,
// streaming, reset in the full state, a forward->inverse loopback and counter wrap.
module tb_inv_shift_rows_stage;

    localparam int LB_N = 1000;

    logic clk;
    logic rst;

    int compared;
    int mismatched;

    inv_shift_rows_stage_if a_in ();
    inv_shift_rows_stage_if a_out ();
    inv_shift_rows_stage_if lb_in ();
    inv_shift_rows_stage_if lb_mid ();
    inv_shift_rows_stage_if lb_out ();
    inv_shift_rows_stage_if w_in ();
    inv_shift_rows_stage_if w_out ();

    logic [31:0] cnt_a;
    logic [31:0] cnt_fwd;
    logic [31:0] cnt_inv;
    logic [3:0]  cnt_w;

    inv_shift_rows_stage #(.INVERSE(1'b1), .CNT_W(32)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .in_if   (a_in),
        .out_if  (a_out),
        .blk_cnt (cnt_a)
    );

    inv_shift_rows_stage #(.INVERSE(1'b0), .CNT_W(32)) u_fwd (
        .clk     (clk),
        .rst     (rst),
        .in_if   (lb_in),
        .out_if  (lb_mid),
        .blk_cnt (cnt_fwd)
    );

    inv_shift_rows_stage #(.INVERSE(1'b1), .CNT_W(32)) u_inv (
        .clk     (clk),
        .rst     (rst),
        .in_if   (lb_mid),
        .out_if  (lb_out),
        .blk_cnt (cnt_inv)
    );

    inv_shift_rows_stage #(.INVERSE(1'b1), .CNT_W(4)) u_wrap (
        .clk     (clk),
        .rst     (rst),
        .in_if   (w_in),
        .out_if  (w_out),
        .blk_cnt (cnt_w)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: gathers each row into a 32-bit word and rotates it
    // right (inverse) or left (forward) by r bytes.
    function automatic logic [127:0] refShift(input logic [127:0] st, input bit inv);
        logic [127:0] res;
        logic [31:0]  row;
        logic [63:0]  dbl;
        res = st;
        for (int r = 0; r < 4; r++) begin
            row = {st[127-8*r -: 8], st[127-8*(4+r) -: 8],
                   st[127-8*(8+r) -: 8], st[127-8*(12+r) -: 8]};
            dbl = {row, row};
            if (inv) begin
                row = 32'(dbl >> (8*r));
            end else begin
                row = 32'(dbl >> (32 - 8*r));
            end
            res[127-8*r -: 8]      = row[31:24];
            res[127-8*(4+r) -: 8]  = row[23:16];
            res[127-8*(8+r) -: 8]  = row[15:8];
            res[127-8*(12+r) -: 8] = row[7:0];
        end
        return res;
    endfunction

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive the input side of the main instance.
    task automatic applyStimulus(input logic valid, input logic [127:0] data);
        a_in.valid = valid;
        a_in.data  = data;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] vec_a, vec_b, vec_c, vec_d, vec_e;
    logic [127:0] stream_vec [64];
    logic [127:0] lb_vec [LB_N];
    int           sent, recv, cyc;
    logic         send_fire, recv_fire;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, '0);
        a_out.ready  = 1'b0;
        lb_in.valid  = 1'b0;
        lb_in.data   = '0;
        lb_out.ready = 1'b0;
        w_in.valid   = 1'b0;
        w_in.data    = '0;
        w_out.ready  = 1'b0;

        // Reset state, sampled while rst is still high
        tick();
        tick();
        checkOutput("rst_out_valid", 128'(a_out.valid), 128'd0);
        checkOutput("rst_out_data", a_out.data, 128'd0);
        checkOutput("rst_in_ready", 128'(a_in.ready), 128'd0);
        checkOutput("rst_blk_cnt", 128'(cnt_a), 128'd0);
        rst = 1'b0;
        tick();
        checkOutput("rst_release_in_ready", 128'(a_in.ready), 128'd1);

        // T1: hand-computed InvShiftRows of 00..0f
        vec_a = 128'h000102030405060708090a0b0c0d0e0f;
        a_out.ready = 1'b1;
        applyStimulus(1'b1, vec_a);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("t1_out_valid", 128'(a_out.valid), 128'd1);
        checkOutput("t1_out_data", a_out.data, 128'h000d0a07_04010e0b_0805020f_0c090603);
        tick();
        checkOutput("t1_blk_cnt", 128'(cnt_a), 128'd1);
        checkOutput("t1_idle_valid", 128'(a_out.valid), 128'd0);
        checkOutput("t1_hold_data", a_out.data, 128'h000d0a07_04010e0b_0805020f_0c090603);

        // T3: backpressure, A and B fill the buffer, C must wait
        vec_a = 128'h11223344_55667788_99aabbcc_ddeeff00;
        vec_b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        vec_c = 128'hdeadbeef_cafebabe_01234567_89abcdef;
        a_out.ready = 1'b0;
        applyStimulus(1'b1, vec_a);
        tick();
        checkOutput("t3_a_valid", 128'(a_out.valid), 128'd1);
        checkOutput("t3_a_data", a_out.data, refShift(vec_a, 1'b1));
        checkOutput("t3_ready_after_a", 128'(a_in.ready), 128'd1);
        applyStimulus(1'b1, vec_b);
        tick();
        checkOutput("t3_ready_after_b", 128'(a_in.ready), 128'd0);
        checkOutput("t3_hold_a_1", a_out.data, refShift(vec_a, 1'b1));
        applyStimulus(1'b1, vec_c);
        tick();
        checkOutput("t3_ready_full", 128'(a_in.ready), 128'd0);
        checkOutput("t3_hold_a_2", a_out.data, refShift(vec_a, 1'b1));
        checkOutput("t3_hold_valid", 128'(a_out.valid), 128'd1);
        a_out.ready = 1'b1;
        tick();
        checkOutput("t3_out_b", a_out.data, refShift(vec_b, 1'b1));
        checkOutput("t3_ready_drain", 128'(a_in.ready), 128'd1);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("t3_out_c", a_out.data, refShift(vec_c, 1'b1));
        checkOutput("t3_out_c_valid", 128'(a_out.valid), 128'd1);
        tick();
        checkOutput("t3_empty", 128'(a_out.valid), 128'd0);
        checkOutput("t3_blk_cnt", 128'(cnt_a), 128'd4);

        // T4: 64 back-to-back states at full rate
        for (int i = 0; i < 64; i++) begin
            stream_vec[i] = {32'(i) * 32'h01010101, 32'h9e3779b9 ^ 32'(i),
                             32'h7f4a7c15 + 32'(i * 17), ~32'(i)};
        end
        a_out.ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, stream_vec[i]);
            tick();
            checkOutput("t4_in_ready", 128'(a_in.ready), 128'd1);
            checkOutput("t4_out_valid", 128'(a_out.valid), 128'd1);
            checkOutput("t4_out_data", a_out.data, refShift(stream_vec[i], 1'b1));
        end
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("t4_blk_cnt", 128'(cnt_a), 128'd68);

        // T6: fill to two entries, then a one-cycle reset discards both
        vec_d = 128'h01010101_02020202_03030303_04040404;
        vec_e = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
        a_out.ready = 1'b0;
        applyStimulus(1'b1, vec_d);
        tick();
        applyStimulus(1'b1, vec_e);
        tick();
        checkOutput("t6_full", 128'(a_in.ready), 128'd0);
        applyStimulus(1'b0, '0);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst_valid", 128'(a_out.valid), 128'd0);
        checkOutput("t6_rst_data", a_out.data, 128'd0);
        checkOutput("t6_rst_cnt", 128'(cnt_a), 128'd0);
        checkOutput("t6_rst_ready", 128'(a_in.ready), 128'd0);
        rst = 1'b0;
        a_out.ready = 1'b1;
        tick();
        checkOutput("t6_ready_after", 128'(a_in.ready), 128'd1);
        checkOutput("t6_no_old_1", 128'(a_out.valid), 128'd0);
        tick();
        checkOutput("t6_no_old_2", 128'(a_out.valid), 128'd0);
        checkOutput("t6_cnt_after", 128'(cnt_a), 128'd0);

        // T2 (directed part): hand-computed forward ShiftRows in the middle,
        // original state back at the end
        vec_a = 128'h000102030405060708090a0b0c0d0e0f;
        lb_out.ready = 1'b1;
        lb_in.valid  = 1'b1;
        lb_in.data   = vec_a;
        tick();
        lb_in.valid = 1'b0;
        checkOutput("lb_fwd_data", lb_mid.data, 128'h00050a0f_04090e03_080d0207_0c01060b);
        tick();
        checkOutput("lb_dir_valid", 128'(lb_out.valid), 128'd1);
        checkOutput("lb_dir_data", lb_out.data, vec_a);
        tick();

        // T2 (random part): random states, random stalls on both ends
        for (int i = 0; i < LB_N; i++) begin
            lb_vec[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < LB_N && cyc < 20000) begin
            lb_in.valid  = (sent < LB_N) && ($urandom_range(0, 3) != 0);
            lb_in.data   = lb_vec[(sent < LB_N) ? sent : 0];
            lb_out.ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            send_fire = lb_in.valid & lb_in.ready;
            recv_fire = lb_out.valid & lb_out.ready;
            if (recv_fire) begin
                checkOutput("lb_data", lb_out.data, lb_vec[recv]);
                recv++;
            end
            if (send_fire) begin
                sent++;
            end
            tick();
            cyc++;
        end
        lb_in.valid  = 1'b0;
        lb_out.ready = 1'b0;
        checkOutput("lb_all_received", 128'(recv), 128'(LB_N));
        tick();
        checkOutput("lb_fwd_cnt", 128'(cnt_fwd), 128'(LB_N + 1));
        checkOutput("lb_inv_cnt", 128'(cnt_inv), 128'(LB_N + 1));
        checkOutput("lb_drained", 128'(lb_out.valid), 128'd0);

        // T5: 4-bit counter wraps after 16 handshakes
        w_out.ready = 1'b1;
        w_in.valid  = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            w_in.data = {4{32'(c) * 32'h00010203}};
            tick();
            if (c == 17) begin
                w_in.valid = 1'b0;
            end
            if (c == 16) begin
                checkOutput("t5_cnt_15", 128'(cnt_w), 128'd15);
            end
            if (c == 17) begin
                checkOutput("t5_cnt_wrap", 128'(cnt_w), 128'd0);
            end
            if (c == 18) begin
                checkOutput("t5_cnt_1", 128'(cnt_w), 128'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
